fetch_unit: RTL

Instruction fetch and program-counter stage feeding the CPU control FSM. Holds the 16-bit PC and applies the FSM's `PCEn`/`PCState` updates: increment, signed relative branch, register jump, or not-taken increment. On request it reads the instruction word at PC from program memory over a req/ack handshake, then presents it with a valid flag. Exposes `PC+1` as the link value for jump-and-link.

---
 rtl/fetch_unit.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch / program-counter stage.
// Holds the PC, applies control-FSM PC updates (increment, relative branch,
// register jump, not-taken increment) and fetches the word at PC over a
// req/ack handshake. A PC update that arrives while a fetch is outstanding
// is parked in a one-entry slot and applied when the fetch finishes.
module fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                MAX_WAIT = 15
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              PCEn,
  input  logic [1:0]        PCState,
  input  logic [7:0]        Disp,
  input  logic [ADDR_W-1:0] RegTarget,
  input  logic              FetchReq,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRd,
  input  logic              MemAck,
  input  logic [15:0]       MemData,
  output logic [15:0]       Instr,
  output logic              InstrValid,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] LinkPC,
  output logic              Busy,
  output logic              FetchErr
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  // Last wait count value before the timeout fires.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   link_q, link_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [15:0]         instr_q, instr_d;
  logic                instr_valid_q, instr_valid_d;
  logic [7:0]          wait_cnt_q, wait_cnt_d;
  logic                mem_rd_q, mem_rd_d;
  logic                busy_q, busy_d;
  logic                fetch_err_q, fetch_err_d;
  logic                pend_valid_q, pend_valid_d;
  logic [1:0]          pend_sel_q, pend_sel_d;
  logic [7:0]          pend_disp_q, pend_disp_d;
  logic [ADDR_W-1:0]   pend_tgt_q, pend_tgt_d;
  logic                leave_req;

  // New PC for a given update select; all arithmetic wraps at 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] calc_pc(
    input logic [1:0]        sel,
    input logic [7:0]        disp,
    input logic [ADDR_W-1:0] tgt,
    input logic [ADDR_W-1:0] base
  );
    logic [ADDR_W-1:0] r;
    case (sel)
      2'b01:   r = base + {{(ADDR_W-8){disp[7]}}, disp};
      2'b10:   r = tgt;
      default: r = base + ADDR_W'(1);
    endcase
    return r;
  endfunction

  // Next-state, PC update and pending-slot logic.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    mem_addr_d    = mem_addr_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    wait_cnt_d    = wait_cnt_q;
    pend_valid_d  = pend_valid_q;
    pend_sel_d    = pend_sel_q;
    pend_disp_d   = pend_disp_q;
    pend_tgt_d    = pend_tgt_q;
    leave_req     = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (FetchReq) begin
          state_d       = REQ;
          mem_addr_d    = pc_q;   // old PC even if PCEn fires on this edge
          instr_valid_d = 1'b0;
          wait_cnt_d    = '0;
        end
        if (PCEn) begin
          pc_d = calc_pc(PCState, Disp, RegTarget, pc_q);
        end
      end
      REQ: begin
        if (MemAck) begin
          state_d       = DONE;
          instr_d       = MemData;
          instr_valid_d = 1'b1;
          leave_req     = 1'b1;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d   = ERR;
          leave_req = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end

        if (leave_req) begin
          // Fetch is over: retire the parked update, or one arriving now.
          if (pend_valid_q) begin
            pc_d         = calc_pc(pend_sel_q, pend_disp_q, pend_tgt_q, pc_q);
            pend_valid_d = 1'b0;
          end else if (PCEn) begin
            pc_d = calc_pc(PCState, Disp, RegTarget, pc_q);
          end
        end else if (PCEn && !pend_valid_q) begin
          // Park the update; further strobes while full are dropped.
          pend_valid_d = 1'b1;
          pend_sel_d   = PCState;
          pend_disp_d  = Disp;
          pend_tgt_d   = RegTarget;
        end
      end
      default: begin
        instr_valid_d = 1'b0;
      end
    endcase
  end

  // Registered output decodes derived from the next state.
  always_comb begin
    link_d      = pc_d + ADDR_W'(1);
    mem_rd_d    = (state_d == REQ);
    busy_d      = (state_d == REQ);
    fetch_err_d = (state_d == ERR);
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      link_q        <= RESET_PC + ADDR_W'(1);
      mem_addr_q    <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      wait_cnt_q    <= '0;
      mem_rd_q      <= 1'b0;
      busy_q        <= 1'b0;
      fetch_err_q   <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_sel_q    <= '0;
      pend_disp_q   <= '0;
      pend_tgt_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      link_q        <= link_d;
      mem_addr_q    <= mem_addr_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_rd_q      <= mem_rd_d;
      busy_q        <= busy_d;
      fetch_err_q   <= fetch_err_d;
      pend_valid_q  <= pend_valid_d;
      pend_sel_q    <= pend_sel_d;
      pend_disp_q   <= pend_disp_d;
      pend_tgt_q    <= pend_tgt_d;
    end
  end

  assign PC         = pc_q;
  assign LinkPC     = link_q;
  assign MemAddr    = mem_addr_q;
  assign MemRd      = mem_rd_q;
  assign Busy       = busy_q;
  assign Instr      = instr_q;
  assign InstrValid = instr_valid_q;
  assign FetchErr   = fetch_err_q;

endmodule
